// File: rtl/io_timer.sv
// io_timer: memory-mapped I/O port and 16-bit interval timer on the cpu6502 bus.
// Eight-byte register window at BASE, decoded from the CPU's next-cycle bus
// signals, with a registered read path. Drives irq/nmi from software-forced
// IO_PORT bits and from the timer underflow flag.
// Optional build macro: IO_TIMER_LATCH_READ_EN adds a THI read shadow that
// is captured on a TLO read, so a TLO-then-THI read pair is coherent.
module io_timer #(
  parameter logic [15:0] BASE     = 16'hbff8,
  parameter int unsigned PRESCALE = 16,
  parameter logic [7:0]  IO_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr_next,
  input  logic        we_next,
  input  logic [7:0]  wdata,
  output logic [7:0]  rd_data,
  output logic        sel,
  output logic [7:0]  io_out,
  output logic        irq,
  output logic        nmi
);

  localparam int unsigned PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [7:0]    io_q, io_d;
  logic [15:0]   reload_q, reload_d;
  logic [15:0]   count_q, count_d;
  logic [3:0]    ctrl_q, ctrl_d;      // {NSEL, IE, CONT, EN}
  logic          uf_q, uf_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    rd_q, rd_d;
  logic          sel_q, sel_d;
  logic [7:0]    thi_rd;

  logic       hit, wr, rd;
  logic [2:0] off;
  logic       wr_io, wr_tlo, wr_thi, wr_ctrl, wr_stat;
  logic       tick, underflow;

  assign hit     = (addr_next[15:3] == BASE[15:3]);
  assign off     = addr_next[2:0];
  assign wr      = hit & we_next;
  assign rd      = hit & ~we_next;
  assign wr_io   = wr && (off == 3'd0);
  assign wr_tlo  = wr && (off == 3'd1);
  assign wr_thi  = wr && (off == 3'd2);
  assign wr_ctrl = wr && (off == 3'd3);
  assign wr_stat = wr && (off == 3'd4);

  // A THI load takes precedence over a coincident tick, so that tick is dropped.
  assign tick      = ctrl_q[0] && (pre_q == PRE_MAX) && !wr_thi;
  assign underflow = tick && (count_q == 16'd0);

  assign irq    = io_q[0] | (uf_q & ctrl_q[2] & ~ctrl_q[3]);
  assign nmi    = io_q[1] | (uf_q & ctrl_q[2] &  ctrl_q[3]);
  assign io_out = io_q;
  assign rd_data = rd_q;
  assign sel     = sel_q;

`ifdef IO_TIMER_LATCH_READ_EN
  logic [7:0] shadow_q, shadow_d;

  // Shadow high byte: captured on a TLO read, overwritten by a THI load.
  always_comb begin
    shadow_d = shadow_q;
    if (rd && (off == 3'd1)) shadow_d = count_q[15:8];
    if (wr_thi)              shadow_d = wdata;
  end

  assign thi_rd = shadow_q;

  // Shadow register state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) shadow_q <= 8'hff;
    else        shadow_q <= shadow_d;
  end
`else
  assign thi_rd = count_q[15:8];
`endif

  // Next-state logic for registers, prescaler, counter and flags.
  always_comb begin
    io_d     = wr_io ? wdata : io_q;

    reload_d = reload_q;
    if (wr_tlo) reload_d[7:0]  = wdata;
    if (wr_thi) reload_d[15:8] = wdata;

    if (wr_thi || !ctrl_q[0] || (pre_q == PRE_MAX)) pre_d = '0;
    else                                            pre_d = pre_q + 1'b1;

    count_d = count_q;
    if (wr_thi)                 count_d = {wdata, reload_q[7:0]};
    else if (tick) begin
      if (count_q != 16'd0)     count_d = count_q - 16'd1;
      else if (ctrl_q[1])       count_d = reload_q;
    end

    // One-shot underflow stops the timer; an explicit CTRL write overrides it.
    ctrl_d = ctrl_q;
    if (underflow && !ctrl_q[1]) ctrl_d[0] = 1'b0;
    if (wr_ctrl)                 ctrl_d    = wdata[3:0];

    // Underflow set beats a simultaneous write-1-to-clear.
    uf_d = uf_q;
    if (wr_stat && wdata[0]) uf_d = 1'b0;
    if (underflow)           uf_d = 1'b1;

    sel_d = hit;
    rd_d  = 8'h00;
    if (hit) begin
      case (off)
        3'd0:    rd_d = io_q;
        3'd1:    rd_d = count_q[7:0];
        3'd2:    rd_d = thi_rd;
        3'd3:    rd_d = {4'h0, ctrl_q};
        3'd4:    rd_d = {irq, 6'b000000, uf_q};
        default: rd_d = 8'h00;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      io_q     <= IO_RESET;
      reload_q <= 16'hffff;
      count_q  <= 16'hffff;
      ctrl_q   <= 4'h0;
      uf_q     <= 1'b0;
      pre_q    <= '0;
      rd_q     <= 8'h00;
      sel_q    <= 1'b0;
    end else begin
      io_q     <= io_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      ctrl_q   <= ctrl_d;
      uf_q     <= uf_d;
      pre_q    <= pre_d;
      rd_q     <= rd_d;
      sel_q    <= sel_d;
    end
  end

endmodule

// File: tb/tb_io_timer.sv
// tb_io_timer: table-driven register checks plus hand-written timer sequences
// for io_timer with default parameters (BASE=bff8, PRESCALE=16, IO_RESET=00).
module tb_io_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] addr_next = 16'h0000;
  logic        we_next = 1'b0;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  rd_data;
  logic        sel;
  logic [7:0]  io_out;
  logic        irq;
  logic        nmi;

  io_timer dut (
    .clk       (clk),
    .reset     (reset),
    .addr_next (addr_next),
    .we_next   (we_next),
    .wdata     (wdata),
    .rd_data   (rd_data),
    .sel       (sel),
    .io_out    (io_out),
    .irq       (irq),
    .nmi       (nmi)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [15:0] B = 16'hbff8;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wd;
    logic        chk_rd;
    logic [7:0]  rd;
    logic        sel;
    logic [7:0]  io;
    logic        irq;
    logic        nmi;
  } vec_t;
  vec_t vt[23];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else
      $display("ok   %s: %h", name, act);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else
      $display("ok   %s: %0d", name, act);
  endtask

  // One bus cycle: present next-cycle signals, take the edge, sample 1ns later.
  task automatic bus(input logic [15:0] a, input logic we, input logic [7:0] d);
    addr_next = a;
    we_next   = we;
    wdata     = d;
    @(posedge clk);
    #1;
    addr_next = 16'h0000;
    we_next   = 1'b0;
    wdata     = 8'h00;
  endtask

  task automatic do_wr(input logic [2:0] off, input logic [7:0] d);
    bus(B | {13'b0, off}, 1'b1, d);
  endtask

  task automatic do_rd(input logic [2:0] off, input logic [7:0] exp, input string name);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    bus(B | {13'b0, off}, 1'b0, 8'h00);
    e = sb_q.pop_front();
    check8(e.name, rd_data, e.exp);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait (bounded) for irq or nmi to be high after an edge; t = cycle stamp or -1.
  task automatic wait_out(input bit use_nmi, input int limit, output int t);
    t = -1;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk);
      #1;
      if ((use_nmi ? nmi : irq) === 1'b1) begin
        t = cyc;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, hits;

    // addr we wd chk rd sel io irq nmi
    vt[0]  = '{16'hbff9, 1'b0, 8'h00, 1'b1, 8'hff, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[1]  = '{16'hbffa, 1'b0, 8'h00, 1'b1, 8'hff, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[2]  = '{16'hbffb, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[3]  = '{16'hbffc, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[4]  = '{16'hbff8, 1'b1, 8'h03, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 1'b1};
    vt[5]  = '{16'hbff8, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 8'h03, 1'b1, 1'b1};
    vt[6]  = '{16'hbffc, 1'b0, 8'h00, 1'b1, 8'h80, 1'b1, 8'h03, 1'b1, 1'b1};
    vt[7]  = '{16'hbff8, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[8]  = '{16'hbff8, 1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0};
    vt[9]  = '{16'hbff8, 1'b1, 8'h02, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 1'b1};
    vt[10] = '{16'hbff8, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[11] = '{16'hbffd, 1'b1, 8'haa, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[12] = '{16'hbffd, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[13] = '{16'hbfff, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[14] = '{16'hbffb, 1'b1, 8'hf8, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[15] = '{16'hbffb, 1'b0, 8'h00, 1'b1, 8'h08, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[16] = '{16'hbffb, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[17] = '{16'hbff9, 1'b1, 8'h34, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[18] = '{16'hbffa, 1'b1, 8'h12, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[19] = '{16'hbff9, 1'b0, 8'h00, 1'b1, 8'h34, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[20] = '{16'hbffa, 1'b0, 8'h00, 1'b1, 8'h12, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[21] = '{16'hc000, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[22] = '{16'hbff0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

    // Reset state, checked while reset is held low.
    #12;
    check8("rst_rd_data", rd_data, 8'h00);
    check8("rst_sel", {7'b0, sel}, 8'h00);
    check8("rst_io_out", io_out, 8'h00);
    check8("rst_irq", {7'b0, irq}, 8'h00);
    check8("rst_nmi", {7'b0, nmi}, 8'h00);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Register map vectors.
    for (int i = 0; i < 23; i++) begin
      sb_t e;
      if (vt[i].chk_rd) begin
        e.name = $sformatf("vec%0d_rd", i);
        e.exp  = vt[i].rd;
        sb_q.push_back(e);
      end
      bus(vt[i].addr, vt[i].we, vt[i].wd);
      if (vt[i].chk_rd) begin
        e = sb_q.pop_front();
        check8(e.name, rd_data, e.exp);
      end
      check8($sformatf("vec%0d_sel", i), {7'b0, sel}, {7'b0, vt[i].sel});
      check8($sformatf("vec%0d_io", i), io_out, vt[i].io);
      check8($sformatf("vec%0d_irq", i), {7'b0, irq}, {7'b0, vt[i].irq});
      check8($sformatf("vec%0d_nmi", i), {7'b0, nmi}, {7'b0, vt[i].nmi});
    end

    // Periodic timer: reload 4, prescale 16 -> 80 clk period.
    do_wr(3'd1, 8'h04);
    do_wr(3'd2, 8'h00);
    do_wr(3'd3, 8'h07);
    t0 = cyc;
    wait_out(1'b0, 200, t1);
    check_int("periodic_first_uf", (t1 < 0) ? -1 : t1 - t0, 80);
    do_wr(3'd4, 8'h01);
    check8("periodic_clear_irq", {7'b0, irq}, 8'h00);
    wait_out(1'b0, 200, t2);
    check_int("periodic_second_uf", (t2 < 0) ? -1 : t2 - t1, 80);
    do_wr(3'd3, 8'h00);
    do_wr(3'd4, 8'h01);
    check8("periodic_off_irq", {7'b0, irq}, 8'h00);

    // One-shot: reload 2 -> single UF after 48 clks, EN cleared, count held at 0.
    do_wr(3'd1, 8'h02);
    do_wr(3'd2, 8'h00);
    do_wr(3'd3, 8'h05);
    t0 = cyc;
    wait_out(1'b0, 200, t1);
    check_int("oneshot_uf", (t1 < 0) ? -1 : t1 - t0, 48);
    do_rd(3'd3, 8'h04, "oneshot_ctrl");
    do_rd(3'd1, 8'h00, "oneshot_tlo");
    do_rd(3'd2, 8'h00, "oneshot_thi");
    do_wr(3'd4, 8'h01);
    hits = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (irq === 1'b1) hits++;
    end
    check_int("oneshot_no_more_uf", hits, 0);
    do_rd(3'd1, 8'h00, "oneshot_tlo_held");

    // NSEL routing: reload 0 -> nmi after 16 clks, irq stays low.
    do_wr(3'd1, 8'h00);
    do_wr(3'd2, 8'h00);
    do_wr(3'd3, 8'h0d);
    t0 = cyc;
    wait_out(1'b1, 100, t1);
    check_int("nsel_uf", (t1 < 0) ? -1 : t1 - t0, 16);
    check8("nsel_irq", {7'b0, irq}, 8'h00);
    do_wr(3'd4, 8'h01);
    check8("nsel_clear_nmi", {7'b0, nmi}, 8'h00);

    // Continuous underflow every 16 clks; a clear on an underflow edge loses.
    do_wr(3'd3, 8'h0f);
    t0 = cyc;
    wait_out(1'b1, 100, t1);
    check_int("cont_nmi_uf", (t1 < 0) ? -1 : t1 - t0, 16);
    idle((t0 + 31) - cyc);
    do_wr(3'd4, 8'h01);
    check8("set_beats_clear_nmi", {7'b0, nmi}, 8'h01);
    do_rd(3'd4, 8'h01, "set_beats_clear_status");
    do_wr(3'd4, 8'h01);
    check8("offedge_clear_nmi", {7'b0, nmi}, 8'h00);
    do_wr(3'd3, 8'h00);
    do_wr(3'd4, 8'h01);

    // Coherent 16-bit read across a borrow from 0x0100 to 0x00ff.
    do_wr(3'd1, 8'h00);
    do_wr(3'd2, 8'h01);
    do_wr(3'd3, 8'h01);
    do_rd(3'd1, 8'h00, "latch_tlo");
    idle(20);
`ifdef IO_TIMER_LATCH_READ_EN
    do_rd(3'd2, 8'h01, "latch_thi_shadow");
`else
    do_rd(3'd2, 8'h00, "latch_thi_live");
`endif
    do_rd(3'd1, 8'hff, "latch_tlo_after");
    do_wr(3'd3, 8'h00);

    // Asynchronous reset in the middle of a count.
    do_wr(3'd1, 8'h34);
    do_wr(3'd2, 8'h12);
    do_wr(3'd0, 8'h03);
    do_wr(3'd3, 8'h05);
    idle(5);
    do_rd(3'd0, 8'h03, "pre_reset_io");
    #2;
    reset = 1'b0;
    #1;
    check8("areset_rd_data", rd_data, 8'h00);
    check8("areset_sel", {7'b0, sel}, 8'h00);
    check8("areset_io_out", io_out, 8'h00);
    check8("areset_irq", {7'b0, irq}, 8'h00);
    check8("areset_nmi", {7'b0, nmi}, 8'h00);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    do_rd(3'd1, 8'hff, "post_reset_tlo");
    do_rd(3'd2, 8'hff, "post_reset_thi");
    do_rd(3'd3, 8'h00, "post_reset_ctrl");
    do_rd(3'd4, 8'h00, "post_reset_status");
    do_rd(3'd0, 8'h00, "post_reset_io");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_timer.md
Name: io_timer

Overview:
- Memory-mapped I/O and interval-timer slave on the cpu6502 bus.
- Decodes `address_next` / `write_next` / `data_o_next` exactly as the synchronous RAM does. Read data is registered, so it is valid while `address` equals the accessed location.
- Supersedes the bare I/O port register. It produces the `irq` and `nmi` lines consumed by the CPU, from software-forced bits and a 16-bit down-counter with prescaler.
- The system data mux selects `rd_data` whenever `sel` is high.

Parameters:
BASE, 16'hbff8, base address of the 8-byte register window (BASE[2:0] must be 0)
PRESCALE, 16, clk cycles per timer tick (>=1)
IO_RESET, 8'h00, reset value of IO_PORT register

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
addr_next  in  16  CPU next-cycle address (cpu address_next)
we_next  in  1  CPU next-cycle write strobe (cpu write_next)
wdata  in  8  CPU next-cycle write data (cpu data_o_next)
rd_data  out  8  registered read data
sel  out  1  registered: previous addr_next hit window; steers system read mux and blocks RAM write
io_out  out  8  IO_PORT register contents
irq  out  1  level interrupt request to CPU
nmi  out  1  non-maskable request to CPU

Behaviour:
- Hit: `hit = (addr_next[15:3] == BASE[15:3])`; `off = addr_next[2:0]`.
- On each clk edge: `sel <= hit`. If hit, `rd_data <=` the register at `off`; otherwise `rd_data <= 0`.
- Writes take effect on the same edge when `hit && we_next`.
- Register map (off: name, access):
  - 0: IO_PORT rw.
  - 1: TLO. Write sets reload[7:0]. Read returns count[7:0].
  - 2: THI. Write sets reload[15:8], loads `count <= {wdata, reload[7:0]}`, clears prescaler. Read returns count[15:8].
  - 3: CTRL rw. bit0 EN, bit1 CONT (auto-reload), bit2 IE, bit3 NSEL (route to nmi), bits7:4 read 0.
  - 4: STATUS. bit0 UF flag; bit7 = irq output. Writing 1 to bit0 clears UF.
  - 5-7: read 8'h00, writes ignored.
- Reset (async, reset low):
  - IO_PORT=IO_RESET; reload=16'hffff; count=16'hffff; CTRL=0; UF=0; prescaler=0.
  - rd_data=0; sel=0.
  - irq and nmi follow from the reset register values: with IO_RESET=0 both are 0.
  - Reset may assert mid-count: everything returns to reset values immediately, with no pending UF.
- Prescaler: counts 0..PRESCALE-1 while EN=1. `tick` is asserted in the cycle it equals PRESCALE-1, then it wraps to 0. Held at 0 while EN=0.
- Counter, on tick:
  - If count != 0: `count <= count-1`.
  - If count == 0: UF <= 1. If CONT, `count <= reload`; else `count` stays 0 and EN <= 0.
  - Underflow period is therefore (reload+1)*PRESCALE clks.
- Simultaneous events:
  - Underflow set and STATUS clear write in the same cycle: set wins, UF=1.
  - THI write and tick in the same cycle: the THI load wins and no decrement occurs.
  - CTRL write clearing EN and underflow in the same cycle: UF still sets.
- Outputs, combinational from registers:
  - `irq = IO_PORT[0] | (UF & IE & ~NSEL)`
  - `nmi = IO_PORT[1] | (UF & IE & NSEL)`
  - `io_out = IO_PORT`
- Latency:
  - Read data is visible 1 clk after addr_next is presented.
  - irq/nmi rise 0 clk after UF is registered.

Optional Feature:
- Macro: IO_TIMER_LATCH_READ_EN.
- Defined:
  - Reading TLO captures count[15:8] into an 8-bit shadow in the same edge.
  - A subsequent THI read returns the shadow, giving a coherent 16-bit read.
  - The shadow resets to 8'hff.
  - A THI write also updates the shadow to the loaded high byte.
- Not defined: THI reads return live count[15:8]; no shadow register is present.

Test Plan:
- Reset low then high -> rd_data=0, sel=0, irq=0, nmi=0, io_out=8'h00. A read of off 1/2 returns 8'hff/8'hff.
- Write IO_PORT=8'h03 at 16'hbff8 -> io_out=8'h03, irq=1, nmi=1 on the next cycle. Write 8'h00 -> both deassert.
- PRESCALE=16: write TLO=8'h04, THI=8'h00, CTRL=8'h07 -> UF sets and irq rises exactly 80 clks after the CTRL write edge.
  - Next UF follows 80 clks later (CONT=1).
  - Write STATUS=8'h01 -> irq drops the next cycle.
- One-shot: CTRL=8'h05, reload=2 -> one UF after 48 clks, EN reads back 0, count stays 0, no further UF.
- NSEL: CTRL=8'h0d with reload=0 -> nmi=1, irq=0 after 16 clks.
  - Clear-write on the same edge as a second underflow -> UF remains 1.
- Async reset asserted mid-count (count=16'h1234) -> all outputs and registers return to reset values without waiting for clk.
  - With IO_TIMER_LATCH_READ_EN: TLO read at count 16'h0100 then THI read after the decrement -> returns 8'h01.
